// File: rtl/spi_host_cmd_pkg.sv
// Shared types and sizing helpers for the SPI host command sequencer.
package spi_host_cmd_pkg;

  typedef enum logic [1:0] {
    Standard = 2'd0,
    Dual     = 2'd1,
    Quad     = 2'd2,
    RsvdSpd  = 2'd3
  } speed_t;

  // Bit 1 enables the write data path, bit 0 the read path; Dummy drives neither.
  typedef enum logic [1:0] {
    Dummy  = 2'd0,
    RdOnly = 2'd1,
    WrOnly = 2'd2,
    Bidir  = 2'd3
  } reg_direction_t;

  typedef enum logic [2:0] {
    ErrNone  = 3'd0,
    ErrCsid  = 3'd1,
    ErrSpeed = 3'd2,
    ErrBidir = 3'd3,
    ErrChain = 3'd4
  } err_t;

  // configopts fields beyond the clock divider: csnidle/csnlead/csntrail nibbles + fullcyc, cpha, cpol
  localparam int CfgFixW = 15;
  // segment fields beyond the length: speed(2), wr_en, rd_en, csaat
  localparam int SegFixW = 5;

  function automatic int vbits(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/spi_host_cmd_fifo.sv
// Synchronous command FIFO, registered output (no fall-through), occupancy count.
module spi_host_cmd_fifo
  import spi_host_cmd_pkg::*;
#(
  parameter int  Width = 8,
  parameter int  Depth = 4,
  localparam int PtrW  = vbits(Depth),
  localparam int CntW  = vbits(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             wr, rd;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wready_o = (cnt_q != CntW'(Depth));
  assign rvalid_o = (cnt_q != '0);
  assign wr       = wvalid_i & wready_o & ~clr_i;
  assign rd       = rvalid_o & rready_i & ~clr_i;
  assign count_o  = cnt_q;
  // Gate the read data so an empty or freshly reset FIFO presents zeros.
  assign rdata_o  = rvalid_o ? mem[rptr_q] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= ptr_inc(wptr_q);
      if (rd) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(wr) - CntW'(rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_host_cmd_sequencer.sv
// Validates SPI host command segments, tracks CSAAT chains and queues packed commands.
// Optional SPI_HOST_CMD_SEQ_WATERMARK_EN adds a registered occupancy watermark (wm_lvl_i/wm_o).
module spi_host_cmd_sequencer
  import spi_host_cmd_pkg::*;
#(
  parameter int  NumCS   = 1,
  parameter int  Depth   = 4,
  parameter int  LenW    = 24,
  parameter int  ClkDivW = 16,
  localparam int CSW     = vbits(NumCS),
  localparam int CfgW    = ClkDivW + CfgFixW,
  localparam int CmdW    = CSW + LenW + SegFixW + CfgW,
  localparam int CntW    = vbits(Depth + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sw_rst_i,
  input  logic [NumCS-1:0][CfgW-1:0] cfg_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [CSW-1:0]             in_csid_i,
  input  speed_t                     in_speed_i,
  input  reg_direction_t             in_dir_i,
  input  logic [LenW-1:0]            in_len_i,
  input  logic                       in_csaat_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CmdW-1:0]            out_cmd_o,
  output logic [CntW-1:0]            count_o,
  output logic                       chain_open_o,
  output logic                       err_o,
  output err_t                       err_code_o,
  input  logic                       err_clr_i,
`ifdef SPI_HOST_CMD_SEQ_WATERMARK_EN
  input  logic [CntW-1:0]            wm_lvl_i,
  output logic                       wm_o,
`endif
  output logic                       active_o
);

  typedef struct packed {
    logic [ClkDivW-1:0] clkdiv;
    logic [3:0]         csnidle;
    logic [3:0]         csnlead;
    logic [3:0]         csntrail;
    logic               fullcyc;
    logic               cpha;
    logic               cpol;
  } cfg_t;

  typedef struct packed {
    speed_t            speed;
    logic              wr_en;
    logic              rd_en;
    logic [LenW-1:0]   len;
    logic              csaat;
  } seg_t;

  typedef struct packed {
    logic [CSW-1:0] csid;
    seg_t           segment;
    cfg_t           configopts;
  } cmd_t;

  typedef enum logic {ChIdle, ChHeld} chain_e;

  chain_e          state_q, state_d;
  logic [CSW-1:0]  chain_csid_q, chain_csid_d;
  err_t            chk_err;
  logic            fifo_wready, acc, legal, rejected, csid_bad;
  logic [CfgW-1:0] cfg_sel;
  cmd_t            enq_cmd;

  assign in_ready_o = fifo_wready & ~sw_rst_i;
  assign acc        = in_valid_i & in_ready_o;
  assign legal      = acc & (chk_err == ErrNone);
  assign rejected   = acc & (chk_err != ErrNone);
  assign csid_bad   = (32'(in_csid_i) >= 32'(NumCS));

  // Mux built by compare so an out-of-range csid selects zeros instead of indexing past cfg_i.
  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NumCS; i++)
      if (in_csid_i == CSW'(i)) cfg_sel = cfg_i[i];
  end

  always_comb begin
    chk_err = ErrNone;
    if (csid_bad)                                           chk_err = ErrCsid;
    else if (in_speed_i == RsvdSpd)                         chk_err = ErrSpeed;
    else if (in_dir_i == Bidir && in_speed_i != Standard)   chk_err = ErrBidir;
    else if (chain_open_o && in_csid_i != chain_csid_q)     chk_err = ErrChain;
  end

  always_comb begin
    enq_cmd                = '0;
    enq_cmd.csid           = in_csid_i;
    enq_cmd.segment.speed  = in_speed_i;
    enq_cmd.segment.wr_en  = in_dir_i[1];
    enq_cmd.segment.rd_en  = in_dir_i[0];
    enq_cmd.segment.len    = in_len_i;
    enq_cmd.segment.csaat  = in_csaat_i;
    enq_cmd.configopts     = cfg_t'(cfg_sel);
  end

  // Chain FSM: only legal commands move it; a rejected one leaves it untouched.
  always_comb begin
    state_d      = state_q;
    chain_csid_d = chain_csid_q;
    if (sw_rst_i) begin
      state_d      = ChIdle;
      chain_csid_d = '0;
    end else if (legal) begin
      if (in_csaat_i) begin
        state_d      = ChHeld;
        chain_csid_d = in_csid_i;
      end else begin
        state_d      = ChIdle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ChIdle;
      chain_csid_q <= '0;
    end else begin
      state_q      <= state_d;
      chain_csid_q <= chain_csid_d;
    end
  end

  assign chain_open_o = (state_q == ChHeld);

  // First error sticks until cleared; a clear coinciding with a new error loads the new one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o      <= 1'b0;
      err_code_o <= ErrNone;
    end else if (sw_rst_i) begin
      err_o      <= 1'b0;
      err_code_o <= ErrNone;
    end else begin
      err_o <= rejected;
      if (rejected && (err_code_o == ErrNone || err_clr_i)) err_code_o <= chk_err;
      else if (err_clr_i)                                   err_code_o <= ErrNone;
    end
  end

  spi_host_cmd_fifo #(
    .Width (CmdW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (sw_rst_i),
    .wvalid_i (legal),
    .wready_o (fifo_wready),
    .wdata_i  (enq_cmd),
    .rvalid_o (out_valid_o),
    .rready_i (out_ready_i),
    .rdata_o  (out_cmd_o),
    .count_o  (count_o)
  );

  assign active_o = chain_open_o | out_valid_o;

`ifdef SPI_HOST_CMD_SEQ_WATERMARK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       wm_o <= 1'b0;
    else if (sw_rst_i) wm_o <= 1'b0;
    else               wm_o <= (count_o <= wm_lvl_i);
  end
`endif

endmodule

// File: tb/tb_spi_host_cmd_sequencer.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_spi_host_cmd_sequencer;
  import spi_host_cmd_pkg::*;

  localparam int NumCS   = 3;
  localparam int Depth   = 4;
  localparam int LenW    = 24;
  localparam int ClkDivW = 16;
  localparam int CSW     = 2;
  localparam int CfgW    = ClkDivW + 15;
  localparam int CmdW    = CSW + LenW + 5 + CfgW;
  localparam int CntW    = 3;

  logic                       clk = 1'b0, rst_n = 1'b0;
  logic                       sw_rst = 1'b0, in_valid = 1'b0, in_csaat = 1'b0;
  logic                       out_ready = 1'b0, err_clr = 1'b0;
  logic [NumCS-1:0][CfgW-1:0] cfg;
  logic [CSW-1:0]             in_csid = '0;
  speed_t                     in_speed = Standard;
  reg_direction_t             in_dir = Dummy;
  logic [LenW-1:0]            in_len = '0;
  logic [CntW-1:0]            wm_lvl = '0;
  logic                       in_ready, out_valid, chain_open, err_o, active, wm;
  logic [CmdW-1:0]            out_cmd;
  logic [CntW-1:0]            count;
  err_t                       err_code;

  spi_host_cmd_sequencer #(
    .NumCS(NumCS), .Depth(Depth), .LenW(LenW), .ClkDivW(ClkDivW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_i(sw_rst), .cfg_i(cfg),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_csid_i(in_csid),
    .in_speed_i(in_speed), .in_dir_i(in_dir), .in_len_i(in_len), .in_csaat_i(in_csaat),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_cmd_o(out_cmd),
    .count_o(count), .chain_open_o(chain_open), .err_o(err_o), .err_code_o(err_code),
    .err_clr_i(err_clr),
`ifdef SPI_HOST_CMD_SEQ_WATERMARK_EN
    .wm_lvl_i(wm_lvl), .wm_o(wm),
`endif
    .active_o(active)
  );

`ifndef SPI_HOST_CMD_SEQ_WATERMARK_EN
  assign wm = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_vec = 0, n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of packed entries, the rest plain flags.
  logic [CmdW-1:0] q[$];
  bit              m_chain, m_err_p, m_wm;
  logic [CSW-1:0]  m_chain_csid;
  err_t            m_code;

  task automatic model_clear();
    q.delete();
    m_chain = 0; m_chain_csid = '0; m_err_p = 0; m_code = ErrNone; m_wm = 0;
  endtask

  always @(posedge clk) begin
    int   sz;
    bit   acc;
    err_t e;
    if (!rst_n || sw_rst) model_clear();
    else begin
      sz   = q.size();
      m_wm = (sz <= int'(wm_lvl));
      acc  = in_valid && sz < Depth;
      e    = ErrNone;
      if (acc) begin
        if (int'(in_csid) >= NumCS)                       e = ErrCsid;
        else if (in_speed == RsvdSpd)                     e = ErrSpeed;
        else if (in_dir == Bidir && in_speed != Standard) e = ErrBidir;
        else if (m_chain && in_csid != m_chain_csid)      e = ErrChain;
      end
      if (sz > 0 && out_ready) void'(q.pop_front());
      m_err_p = acc && e != ErrNone;
      if (m_err_p && (m_code == ErrNone || err_clr)) m_code = e;
      else if (err_clr)                              m_code = ErrNone;
      if (acc && e == ErrNone) begin
        q.push_back({in_csid, in_speed, in_dir[1], in_dir[0], in_len, in_csaat, cfg[in_csid]});
        m_chain = in_csaat;
        if (in_csaat) m_chain_csid = in_csid;
      end
    end
    #1;
    chk("out_valid",  out_valid,  q.size() > 0);
    chk("out_cmd",    out_cmd,    q.size() > 0 ? q[0] : '0);
    chk("count",      count,      q.size());
    chk("in_ready",   in_ready,   q.size() < Depth && !sw_rst);
    chk("chain_open", chain_open, m_chain);
    chk("err_o",      err_o,      m_err_p);
    chk("err_code",   err_code,   m_code);
    chk("active",     active,     m_chain || q.size() > 0);
`ifdef SPI_HOST_CMD_SEQ_WATERMARK_EN
    chk("wm",         wm,         m_wm);
`endif
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [CSW-1:0] c, input speed_t s, input reg_direction_t d,
                      input logic [LenW-1:0] l, input logic a);
    in_valid = 1; in_csid = c; in_speed = s; in_dir = d; in_len = l; in_csaat = a;
    tick();
    in_valid = 0;
  endtask

  initial begin
    int c0, idx;
    cfg[0] = {16'h0011, 15'h0001};
    cfg[1] = {16'h1234, 15'h5678};
    cfg[2] = {16'h7abc, 15'h0123};

    // reset
    tick(2);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_code", err_code, ErrNone);
    chk("rst_active", active, 0);
    rst_n = 1;
    tick();

    // fill to full, then a full-cycle dequeue must not admit a new command
    push(0, Standard, WrOnly, 24'd5, 0);
    push(2, Dual, RdOnly, 24'h100, 0);
    push(1, Quad, WrOnly, 24'd7, 0);
    push(0, Standard, Bidir, 24'd3, 0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    cfg[2] = {16'h5555, 15'h0000};
    out_ready = 1;
    push(1, Standard, Dummy, 24'd1, 0);
    out_ready = 0;
    chk("full_deq_count", count, 3);
    chk("head_csid", out_cmd[CmdW-1 -: CSW], 2);
    chk("head_cfg_sampled", out_cmd[CfgW-1 -: ClkDivW], 16'h7abc);
    chk("head_wr_rd", out_cmd[CfgW+LenW+2 -: 2], 2'b01);
    out_ready = 1; tick(3); out_ready = 0;
    chk("drained", count, 0);

    // latency from empty, then steady enq+deq
    chk("empty_valid", out_valid, 0);
    push(1, Standard, Dummy, 24'd9, 0);
    chk("lat1_valid", out_valid, 1);
    out_ready = 1; in_valid = 1; in_csid = 1; in_speed = Standard; in_dir = WrOnly; in_csaat = 0;
    for (int i = 0; i < 10; i++) begin
      in_len = LenW'(i);
      tick();
      chk("steady_count", count, 1);
    end
    in_valid = 0; tick(); out_ready = 0;

    // csid out of range outranks reserved speed; first error sticks
    c0 = int'(count);
    push(3, RsvdSpd, WrOnly, 24'd0, 0);
    chk("csid_err_o", err_o, 1);
    chk("csid_code", err_code, ErrCsid);
    chk("csid_count", count, c0);
    push(0, RsvdSpd, WrOnly, 24'd0, 0);
    chk("sticky_code", err_code, ErrCsid);
    tick();
    chk("err_pulse_end", err_o, 0);
    err_clr = 1; tick(); err_clr = 0;
    chk("clr_code", err_code, ErrNone);

    // chain lock
    push(0, Standard, WrOnly, 24'd1, 1);
    chk("chain_open", chain_open, 1);
    push(1, Standard, WrOnly, 24'd1, 0);
    chk("chain_err", err_code, ErrChain);
    chk("chain_kept", chain_open, 1);
    push(0, Standard, RdOnly, 24'd2, 0);
    chk("chain_closed", chain_open, 0);
    out_ready = 1; tick(3); out_ready = 0;

    // bidir with quad; clear; sw reset flush
    err_clr = 1; tick(); err_clr = 0;
    push(0, Quad, Bidir, 24'd1, 0);
    chk("bidir_code", err_code, ErrBidir);
    err_clr = 1; tick(); err_clr = 0;
    chk("bidir_clr", err_code, ErrNone);
    push(0, Standard, WrOnly, 24'd1, 0);
    push(1, Dual, RdOnly, 24'd2, 0);
    push(2, Quad, Dummy, 24'd3, 1);
    chk("pre_swrst_count", count, 3);
    sw_rst = 1; #1;
    chk("swrst_in_ready", in_ready, 0);
    tick(); sw_rst = 0;
    chk("swrst_count", count, 0);
    chk("swrst_valid", out_valid, 0);
    chk("swrst_chain", chain_open, 0);

`ifdef SPI_HOST_CMD_SEQ_WATERMARK_EN
    wm_lvl = 1;
    push(0, Standard, WrOnly, 24'd1, 0);
    push(0, Standard, WrOnly, 24'd2, 0);
    tick();
    chk("wm_low", wm, 0);
    out_ready = 1; tick(); out_ready = 0;
    chk("wm_still_low", wm, 0);
    tick();
    chk("wm_rise", wm, 1);
    out_ready = 1; tick(); out_ready = 0;
`endif

    // async reset in the middle of a drain
    push(0, Standard, WrOnly, 24'd1, 0);
    push(1, Standard, WrOnly, 24'd2, 1);
    push(1, Standard, RdOnly, 24'd3, 1);
    out_ready = 1; tick();
    #2 rst_n = 0; out_ready = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_cmd", out_cmd, 0);
    chk("arst_chain", chain_open, 0);
    chk("arst_active", active, 0);
    chk("arst_wm", wm, 0);
    tick(2);
    rst_n = 1;
    tick();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_csid   = CSW'($urandom_range(0, 3));
      in_speed  = ($urandom_range(0, 7) == 0) ? RsvdSpd : speed_t'($urandom_range(0, 2));
      in_dir    = reg_direction_t'($urandom_range(0, 3));
      in_len    = LenW'($urandom);
      in_csaat  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sw_rst    = ($urandom_range(0, 63) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      wm_lvl    = CntW'($urandom_range(0, Depth));
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, NumCS - 1);
        cfg[idx] = CfgW'($urandom);
      end
      tick();
    end

    in_valid = 0; out_ready = 0; sw_rst = 0; err_clr = 0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
